// File: rtl/cvxif_instr_pkg.sv
// ----------------------------------------------------------------------------
// cvxif_instr_pkg
//   Shared instruction definitions for the CV-X-IF coprocessor ALU pipeline.
//   - opcode_t : decoded operation presented on the issue interface
//                (includes the multi-cycle ROR64H / ROR64L rotates).
//   - ror64    : 64-bit rotate-right helper used by the rotate datapath.
//   Any opcode_t encoding not listed below is treated as an unknown
//   (illegal) instruction by the coprocessor.
// ----------------------------------------------------------------------------
package cvxif_instr_pkg;

    typedef enum logic [3:0] {
        ILLEGAL     = 4'd0,
        NOP         = 4'd1,
        ADD         = 4'd2,   // rs1 + rs2
        DOUBLE_RS1  = 4'd3,   // rs1 + rs1
        DOUBLE_RS2  = 4'd4,   // rs2 + rs2
        ADD_MULTI   = 4'd5,   // rs1 + rs2 (+ rs3)
        ADD_RS3_R   = 4'd6,   // rs1 + rs2 (+ rs3), always written to x10
        MADD_RS3_R4 = 4'd7,   // rs1 + rs2 (+ rs3)
        MSUB_RS3_R4 = 4'd8,   // rs1 - rs2 (- rs3)
        NMADD_RS3_R4= 4'd9,   // ~(rs1 + rs2 (+ rs3))
        NMSUB_RS3_R4= 4'd10,  // ~(rs1 - rs2 (- rs3))
        ROR64H      = 4'd11,  // upper half of {rs1,rs2} rotated right by imm
        ROR64L      = 4'd12   // lower half of {rs1,rs2} rotated right by imm
    } opcode_t;

    // Destination register forced for ADD_RS3_R.
    localparam logic [4:0] Rs3RDest = 5'd10;

    // Rotate right by sh (0..63): duplicating the vector lets a plain
    // logical shift produce the wrapped bits in the low half.
    function automatic logic [63:0] ror64(input logic [63:0] v, input logic [5:0] sh);
        logic [127:0] dbl;
        dbl = {v, v} >> sh;
        return dbl[63:0];
    endfunction

endpackage

// File: rtl/copro_result_fifo.sv
// ----------------------------------------------------------------------------
// copro_result_fifo
//   Show-ahead result FIFO for the coprocessor ALU pipeline.
//   Parameters: Depth (entries, power of 2, >=2), Width (entry bits).
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     flush_i         synchronous clear; overrides push and pop
//     push_i, data_i  write request / entry; ignored while full
//     pop_i           remove head; ignored while empty
//     data_o          head entry (all zero while empty)
//     full_o, empty_o occupancy flags
// ----------------------------------------------------------------------------
module copro_result_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);

    // Full blocks a push even when a pop happens in the same cycle.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Head is gated so the outputs read zero whenever nothing is queued,
    // including while reset is asserted.
    assign data_o = empty_o ? '0 : mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                wptr_d = wptr_q + 1'b1;   // power-of-2 depth wraps naturally
            end
            if (do_pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/copro_alu_pipe.sv
// ----------------------------------------------------------------------------
// copro_alu_pipe
//   CV-X-IF coprocessor ALU: single-cycle add-type operations and a
//   multi-cycle 64-bit rotate, with results queued in a FIFO.
//   Ports:
//     clk_i, rst_ni                 clock, asynchronous active-low reset
//     issue_valid_i/issue_ready_o   issue handshake
//     registers_i                   rs1/rs2(/rs3) operand values
//     opcode_i                      decoded operation (cvxif_instr_pkg)
//     hartid_i, id_i, rd_i          tags carried with the result
//     imm_i                         rotate amount for ROR64H/ROR64L
//     flush_i                       kill all queued and in-flight work
//     result_valid_o/result_ready_i result handshake (FIFO head)
//     result_o, hartid_o, id_o,
//     rd_o, we_o                    head entry fields
//     illegal_o                     pulse the cycle after an unknown opcode
//     busy_o                        rotate in flight or results queued
// ----------------------------------------------------------------------------
module copro_alu_pipe
    import cvxif_instr_pkg::*;
#(
    parameter int unsigned NrRgprPorts = 2,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned FifoDepth   = 4,
    parameter int unsigned RotStep     = 8,
    parameter type hartid_t            = logic,
    parameter type id_t                = logic,
    parameter type registers_t         = logic [NrRgprPorts-1:0][XLEN-1:0]
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  registers_t      registers_i,
    input  opcode_t         opcode_i,
    input  hartid_t         hartid_i,
    input  id_t             id_i,
    input  logic [4:0]      rd_i,
    input  logic [5:0]      imm_i,
    input  logic            flush_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [XLEN-1:0] result_o,
    output hartid_t         hartid_o,
    output id_t             id_o,
    output logic [4:0]      rd_o,
    output logic            we_o,
    output logic            illegal_o,
    output logic            busy_o
);

    localparam int unsigned HartW  = $bits(hartid_t);
    localparam int unsigned IdW    = $bits(id_t);
    localparam int unsigned EntryW = XLEN + HartW + IdW + 5 + 1;

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StRotate = 1'b1;

    // RotStep is at most 32, so it always fits the 6-bit remaining count.
    localparam logic [5:0] RotStepAmt = 6'(RotStep);

    // ------------------------------------------------------------------
    // Operand extraction; rs3 reads as zero on a two-port configuration
    // so the three-operand formulas collapse to their two-operand forms.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rs1, rs2, rs3;

    assign rs1 = registers_i[0];
    assign rs2 = registers_i[1];

    generate
        if (NrRgprPorts == 3) begin : g_rs3
            assign rs3 = registers_i[2];
        end else begin : g_no_rs3
            assign rs3 = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Single-cycle decode / ALU
    // ------------------------------------------------------------------
    logic [XLEN-1:0] alu_result;
    logic [4:0]      alu_rd;
    logic            alu_we;
    logic            alu_push;
    logic            is_ror;
    logic            is_illegal;

    always_comb begin
        alu_result = '0;
        alu_rd     = rd_i;
        alu_we     = 1'b1;
        alu_push   = 1'b0;
        is_ror     = 1'b0;
        is_illegal = 1'b0;
        case (opcode_i)
            NOP: begin
                alu_rd   = 5'd0;
                alu_we   = 1'b0;
                alu_push = 1'b1;
            end
            ADD: begin
                alu_result = rs1 + rs2;
                alu_push   = 1'b1;
            end
            DOUBLE_RS1: begin
                alu_result = rs1 + rs1;
                alu_push   = 1'b1;
            end
            DOUBLE_RS2: begin
                alu_result = rs2 + rs2;
                alu_push   = 1'b1;
            end
            ADD_MULTI, MADD_RS3_R4: begin
                alu_result = rs1 + rs2 + rs3;
                alu_push   = 1'b1;
            end
            ADD_RS3_R: begin
                alu_result = rs1 + rs2 + rs3;
                alu_rd     = Rs3RDest;
                alu_push   = 1'b1;
            end
            MSUB_RS3_R4: begin
                alu_result = rs1 - rs2 - rs3;
                alu_push   = 1'b1;
            end
            NMADD_RS3_R4: begin
                alu_result = ~(rs1 + rs2 + rs3);
                alu_push   = 1'b1;
            end
            NMSUB_RS3_R4: begin
                alu_result = ~(rs1 - rs2 - rs3);
                alu_push   = 1'b1;
            end
            ROR64H, ROR64L: begin
                is_ror = 1'b1;
            end
            default: begin
                is_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue handshake
    // ------------------------------------------------------------------
    logic [0:0] state_q, state_d;
    logic       fifo_full, fifo_empty;
    logic       accept;

    // rst_ni gates ready so it reads 0 while reset is held and rises
    // only after release.
    assign issue_ready_o = rst_ni & (state_q == StIdle) & ~fifo_full & ~flush_i;
    assign accept        = issue_valid_i & issue_ready_o;

    // ------------------------------------------------------------------
    // Rotate FSM
    // ------------------------------------------------------------------
    logic [63:0]     vec_q, vec_d;
    logic [5:0]      rem_q, rem_d;
    logic            rot_hi_q, rot_hi_d;
    hartid_t         rot_hartid_q, rot_hartid_d;
    id_t             rot_id_q, rot_id_d;
    logic [4:0]      rot_rd_q, rot_rd_d;
    logic            rot_push;
    logic [5:0]      step_amt;
    logic [XLEN-1:0] rot_result;

    assign step_amt   = (rem_q > RotStepAmt) ? RotStepAmt : rem_q;
    assign rot_result = XLEN'(rot_hi_q ? vec_q[63:32] : vec_q[31:0]);

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        rem_d        = rem_q;
        rot_hi_d     = rot_hi_q;
        rot_hartid_d = rot_hartid_q;
        rot_id_d     = rot_id_q;
        rot_rd_d     = rot_rd_q;
        rot_push     = 1'b0;
        if (flush_i) begin
            state_d = StIdle;
            rem_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept && is_ror) begin
                        state_d      = StRotate;
                        vec_d        = {rs1[31:0], rs2[31:0]};
                        rem_d        = imm_i;
                        rot_hi_d     = (opcode_i == ROR64H);
                        rot_hartid_d = hartid_i;
                        rot_id_d     = id_i;
                        rot_rd_d     = rd_i;
                    end
                end
                StRotate: begin
                    if (rem_q != '0) begin
                        vec_d = ror64(vec_q, step_amt);
                        rem_d = rem_q - step_amt;
                    end else if (!fifo_full) begin
                        rot_push = 1'b1;
                        state_d  = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            vec_q        <= '0;
            rem_q        <= '0;
            rot_hi_q     <= 1'b0;
            rot_hartid_q <= '0;
            rot_id_q     <= '0;
            rot_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            rem_q        <= rem_d;
            rot_hi_q     <= rot_hi_d;
            rot_hartid_q <= rot_hartid_d;
            rot_id_q     <= rot_id_d;
            rot_rd_q     <= rot_rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Illegal-opcode pulse: unknown opcodes are accepted but queue nothing.
    // ------------------------------------------------------------------
    logic illegal_q, illegal_d;

    assign illegal_d = accept & is_illegal;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_o = illegal_q;

    // ------------------------------------------------------------------
    // Result FIFO. The ALU push and the rotate push never coincide: issue
    // is only accepted in IDLE, the rotate only pushes from ROTATE.
    // ------------------------------------------------------------------
    logic              fifo_push;
    logic [EntryW-1:0] push_data;
    logic [EntryW-1:0] head_data;

    assign fifo_push = (accept & alu_push) | rot_push;

    always_comb begin
        if (rot_push) begin
            push_data = {rot_result, rot_hartid_q, rot_id_q, rot_rd_q, 1'b1};
        end else begin
            push_data = {alu_result, hartid_i, id_i, alu_rd, alu_we};
        end
    end

    copro_result_fifo #(
        .Depth (FifoDepth),
        .Width (EntryW)
    ) u_result_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .data_i  (push_data),
        .pop_i   (result_ready_i),
        .data_o  (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign result_valid_o = ~fifo_empty;
    assign {result_o, hartid_o, id_o, rd_o, we_o} = head_data;

    assign busy_o = (state_q == StRotate) | ~fifo_empty;

endmodule

// File: doc/copro_alu_pipe.md
COPRO_ALU_PIPE -- requirements
Module: copro_alu_pipe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NrRgprPorts, 2, register read ports used (2 or 3).
- XLEN, 32, datapath width (32 or 64).
- FifoDepth, 4, result FIFO entries (power of 2, >=2).
- RotStep, 8, rotate bits per cycle (1..32).
- hartid_t, id_t, registers_t: logic, logic, logic; CV-X-IF types.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- issue_valid_i, in, 1, request valid.
- issue_ready_o, out, 1, request accepted when high with issue_valid_i.
- registers_i, in, registers_t, rs1/rs2/rs3 values.
- opcode_i, in, opcode_t, decoded operation.
- hartid_i / id_i, in, hartid_t / id_t, tags.
- rd_i, in, 5, destination register.
- imm_i, in, 6, rotate amount.
- flush_i, in, 1, synchronous kill of all pending work.
- result_valid_o, out, 1, FIFO head valid.
- result_ready_i, in, 1, consumer takes head.
- result_o, out, XLEN, result.
- hartid_o / id_o / rd_o / we_o, out, tag widths/5/1, head fields.
- illegal_o, out, 1, one-cycle pulse on accepted unknown opcode.
- busy_o, out, 1, high when state is ROTATE or FIFO non-empty.

Function
REQ-003 Acceptance SHALL occur on issue_valid_i && issue_ready_o; issue_ready_o = state IDLE && FIFO not full && !flush_i.
REQ-004 NOP, ADD, DOUBLE_RS1/RS2, ADD_MULTI, MADD/MSUB/NMADD/NMSUB_RS3_R4 and ADD_RS3_R SHALL push one entry in the accept cycle; result_valid_o rises the next cycle.
REQ-005 Arithmetic SHALL wrap modulo 2^XLEN; rs3 terms apply only when NrRgprPorts==3, otherwise they are omitted.
REQ-006 NOP SHALL push result 0, rd 0, we 0; ADD_RS3_R SHALL push rd=10, we=1; all other ops SHALL push rd_i, we=1.
REQ-007 An unknown opcode SHALL be accepted, push nothing, and pulse illegal_o in the cycle after acceptance.
REQ-008 ROR64H/ROR64L SHALL form V={rs1[31:0],rs2[31:0]}, then enter ROTATE with rem=imm_i.
REQ-009 In ROTATE with rem>0, V SHALL rotate right by min(RotStep,rem), and rem SHALL decrease by that amount.
REQ-010 In ROTATE with rem==0 and FIFO not full, the FSM SHALL push V[63:32] (H) or V[31:0] (L), zero-extended to XLEN, and return to IDLE; with the FIFO full it SHALL hold.
REQ-011 Rotate latency SHALL be: accepted at T, result_valid_o at T+2+ceil(imm/RotStep) when there is no backpressure.
REQ-012 The FIFO SHALL pop on result_valid_o && result_ready_i, and head outputs SHALL hold while stalled.
REQ-013 Push SHALL be blocked whenever the FIFO is full, even with a simultaneous pop; push and pop in the same non-full cycle SHALL keep the count unchanged.
REQ-014 Entries SHALL emerge in acceptance order.
REQ-015 flush_i SHALL empty the FIFO, return the FSM to IDLE, discard the rotate in flight and block acceptance that cycle; flush has priority over push and pop.

Reset
REQ-016 Reset SHALL be asynchronous on rst_ni low.
REQ-017 During reset the FSM SHALL be IDLE, the FIFO empty and rem 0.
REQ-018 During reset all outputs SHALL be 0 except issue_ready_o, which SHALL be 1 after reset release.
REQ-019 Reset during ROTATE SHALL discard the operation with no result produced.

Structure
REQ-020 opcode_t, including ROR64H/ROR64L, SHALL remain in cvxif_instr_pkg; the FSM state enum (IDLE, ROTATE) SHALL be local.
REQ-021 Result storage SHALL be one sub-module, copro_result_fifo, parametrised by depth and entry width with a flush input.

Verification
REQ-022 ADD rs1=5, rs2=7, rd=3 -> result 12, rd 3, we 1, one cycle after acceptance.
REQ-023 ROR64L rs1=0x00000001, rs2=0x00000000, imm=1, RotStep=8 -> result 0x80000000 at T+3; with imm=63, result_valid_o at T+10.
REQ-024 With result_ready_i=0, issue FifoDepth ADDs -> issue_ready_o low after the 4th; releasing ready -> entries emerge in order.
REQ-025 flush_i mid-ROTATE with 2 entries queued -> next cycle FIFO empty, busy_o 0, no result appears.
REQ-026 NrRgprPorts=3, MSUB_RS3_R4 with 10, 3, 2 -> 5; unknown opcode -> illegal_o pulse and no FIFO entry.
REQ-027 Assert rst_ni during ROTATE -> all outputs 0 immediately; issue_ready_o=1 after release.
